// File: rtl/conv_dp_acc_round.sv
// Per-output-channel dot-product accumulator with bias, round-half-up and saturation.
// Define CONV_ACC_RELU_EN to clamp negative results to zero at writeback.
module conv_dp_acc_round #(
  parameter int IN_WIDTH  = 16,
  parameter int IN_FRAC   = 3,
  parameter int W_WIDTH   = 8,
  parameter int W_FRAC    = 4,
  parameter int B_WIDTH   = 8,
  parameter int B_FRAC    = 4,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 4,
  parameter int DP_SIZE   = 2,
  parameter int ACC_DEPTH = 8,
  parameter int OC_PAR    = 2,
  parameter int HAS_BIAS  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DP_SIZE-1:0][IN_WIDTH-1:0]        data_in,
  input  logic                                   data_in_valid,
  output logic                                   data_in_ready,
  input  logic [OC_PAR*DP_SIZE-1:0][W_WIDTH-1:0]  weight,
  input  logic                                   weight_valid,
  output logic                                   weight_ready,
  input  logic [OC_PAR-1:0][B_WIDTH-1:0]          bias,
  input  logic                                   bias_valid,
  output logic                                   bias_ready,
  output logic [OC_PAR-1:0][OUT_WIDTH-1:0]        data_out,
  output logic                                   data_out_valid,
  input  logic                                   data_out_ready
);

  localparam int PW  = IN_WIDTH + W_WIDTH + $clog2(DP_SIZE);
  localparam int AW  = IN_WIDTH + W_WIDTH + $clog2(DP_SIZE * ACC_DEPTH) + 1;
  localparam int RW  = AW + 1;
  localparam int SH  = IN_FRAC + W_FRAC - OUT_FRAC;
  localparam int BSH = IN_FRAC + W_FRAC - B_FRAC;
  localparam int BW  = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

  localparam logic [BW-1:0]        LAST_BEAT = BW'(ACC_DEPTH - 1);
  localparam logic signed [RW-1:0] RND       = (SH > 0) ? (RW'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] OUT_MAX   = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN   = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // stage 1 and beat tracking
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_last_q;
  logic signed [PW-1:0]   s1_dp_q   [OC_PAR];
  logic signed [AW-1:0]   s1_bias_q [OC_PAR];
  logic [BW-1:0]          beat_q, beat_d;

  // stage 2 accumulators and output register
  logic signed [AW-1:0]             acc_q [OC_PAR];
  logic signed [AW-1:0]             acc_d [OC_PAR];
  logic [OC_PAR-1:0][OUT_WIDTH-1:0] out_q, out_d;
  logic                             out_valid_q, out_valid_d;

  // combinational helpers
  logic                   last;
  logic                   bias_ok;
  logic                   in_ready;
  logic                   in_fire;
  logic                   s1_adv;
  logic signed [PW-1:0]   dp_d     [OC_PAR];
  logic signed [AW-1:0]   bias_al  [OC_PAR];
  logic signed [RW-1:0]   sum_r    [OC_PAR];
  logic signed [RW-1:0]   rnd_sum  [OC_PAR];
  logic signed [RW-1:0]   rnd_sh   [OC_PAR];
  logic [OUT_WIDTH-1:0]   res      [OC_PAR];

  // Handshake: data and weight are taken together, plus bias on the last beat.
  always_comb begin
    last          = (beat_q == LAST_BEAT);
    bias_ok       = !last || (HAS_BIAS == 0) || bias_valid;
    s1_adv        = s1_valid_q && (!s1_last_q || !out_valid_q || data_out_ready);
    in_ready      = !s1_valid_q || s1_adv;
    data_in_ready = rst && weight_valid  && in_ready && bias_ok;
    weight_ready  = rst && data_in_valid && in_ready && bias_ok;
    in_fire       = data_in_valid && data_in_ready;
    bias_ready    = (HAS_BIAS != 0) ? (in_fire && last) : rst;
  end

  always_comb begin
    beat_d = beat_q;
    if (in_fire) begin
      beat_d = last ? '0 : beat_q + BW'(1);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < OC_PAR; i++) begin
      dp_d[i] = '0;
      for (int j = 0; j < DP_SIZE; j++) begin
        dp_d[i] = dp_d[i] + PW'($signed(data_in[j]) * $signed(weight[i*DP_SIZE+j]));
      end
      bias_al[i] = (HAS_BIAS != 0) ? (AW'($signed(bias[i])) <<< BSH) : '0;
    end
  end

  // Writeback: round half-up by adding half an output LSB, then clamp.
  always_comb begin
    for (int i = 0; i < OC_PAR; i++) begin
      sum_r[i]   = RW'(acc_q[i]) + RW'(s1_dp_q[i]) + RW'(s1_bias_q[i]);
      rnd_sum[i] = sum_r[i] + RND;
      rnd_sh[i]  = rnd_sum[i] >>> SH;
      if (rnd_sh[i] > OUT_MAX) begin
        res[i] = OUT_MAX[OUT_WIDTH-1:0];
      end else if (rnd_sh[i] < OUT_MIN) begin
        res[i] = OUT_MIN[OUT_WIDTH-1:0];
      end else begin
        res[i] = rnd_sh[i][OUT_WIDTH-1:0];
      end
`ifdef CONV_ACC_RELU_EN
      if (res[i][OUT_WIDTH-1]) begin
        res[i] = '0;
      end
`endif
    end
  end

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < OC_PAR; i++) begin
      acc_d[i] = acc_q[i];
      if (s1_adv) begin
        if (s1_last_q) begin
          acc_d[i] = '0;
          out_d[i] = res[i];
        end else begin
          acc_d[i] = acc_q[i] + AW'(s1_dp_q[i]);
        end
      end
    end
  end

  // A pop and a new last-beat load in the same cycle keeps valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    if (s1_adv && s1_last_q) begin
      out_valid_d = 1'b1;
    end else if (data_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_dp_q     <= '{default: '0};
      s1_bias_q   <= '{default: '0};
      beat_q      <= '0;
      acc_q       <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      if (in_fire) begin
        s1_last_q <= last;
        s1_dp_q   <= dp_d;
        s1_bias_q <= bias_al;
      end
    end
  end

  assign data_out       = out_q;
  assign data_out_valid = out_valid_q;

endmodule

// File: tb/tb_conv_dp_acc_round.sv
// Scoreboard bench for conv_dp_acc_round: driver pushes model results, monitor pops on output handshakes.
module tb_conv_dp_acc_round;

  localparam int IW = 16;
  localparam int WW = 8;
  localparam int BWD = 8;
  localparam int OW = 16;
  localparam int DP = 2;
  localparam int AD = 8;
  localparam int OC = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [DP-1:0][IW-1:0]     data_in = '0;
  logic                      data_in_valid = 1'b0;
  logic                      data_in_ready;
  logic [OC*DP-1:0][WW-1:0]  weight = '0;
  logic                      weight_valid = 1'b0;
  logic                      weight_ready;
  logic [OC-1:0][BWD-1:0]    bias = '0;
  logic                      bias_valid = 1'b0;
  logic                      bias_ready;
  logic [OC-1:0][OW-1:0]     data_out;
  logic                      data_out_valid;
  logic                      data_out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int beat_n = 0;
  longint lane_sum [OC];
  logic [OC-1:0][OW-1:0] exp_q [$];

  always #5 clk = ~clk;

  conv_dp_acc_round #(
    .IN_WIDTH(16), .IN_FRAC(3), .W_WIDTH(8), .W_FRAC(4), .B_WIDTH(8), .B_FRAC(4),
    .OUT_WIDTH(16), .OUT_FRAC(4), .DP_SIZE(2), .ACC_DEPTH(8), .OC_PAR(2), .HAS_BIAS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
    .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: exact sum of real-valued products in units of 2^-7, bias scaled into
  // the same units, then floor((r + half LSB) / LSB) with LSB = 2^3, then clamp.
  function automatic logic [OW-1:0] ref_result(input longint r);
    longint q;
    q = floor_div(r + 4, 8);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef CONV_ACC_RELU_EN
    if (q < 0) q = 0;
`endif
    return OW'(q);
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       data_out_ready = 1'b1;
      1:       data_out_ready = 1'b0;
      default: data_out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && data_out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h with no result pending (t=%0t)", data_out, $time);
      end else begin
        check("data_out", 64'(data_out), 64'(exp_q[0]));
        if (data_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic [DP-1:0][IW-1:0] d, input logic [OC*DP-1:0][WW-1:0] w,
                           input logic [OC-1:0][BWD-1:0] b, input int gap, input bit probe);
    int cnt;
    bit is_last;
    logic [OC-1:0][OW-1:0] e;
    is_last = (beat_n == AD - 1);
    repeat (gap) @(posedge clk);
    #1;
    data_in = d;
    weight  = w;
    bias    = b;
    if (probe && !is_last) begin
      data_in_valid = 1'b0; weight_valid = 1'b1; bias_valid = 1'b1;
      @(negedge clk);
      check("weight_ready_alone", 64'(weight_ready), 64'(0));
      @(posedge clk); #1;
    end
    if (probe && is_last) begin
      data_in_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b0;
      @(negedge clk);
      check("ready_without_bias", 64'({data_in_ready, weight_ready}), 64'(0));
      @(posedge clk); #1;
    end
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
    bias_valid    = is_last ? 1'b1 : 1'($urandom_range(0, 1));
    cnt = 0;
    @(negedge clk);
    while (!(data_in_ready && weight_ready) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: input not accepted in 300 cycles, beat %0d", beat_n);
      data_in_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
      return;
    end
    check("bias_ready", 64'(bias_ready), 64'(is_last));
    @(posedge clk);
    for (int i = 0; i < OC; i++)
      for (int j = 0; j < DP; j++)
        lane_sum[i] += longint'($signed(d[j])) * longint'($signed(w[i*DP+j]));
    if (is_last) begin
      for (int i = 0; i < OC; i++) begin
        e[i] = ref_result(lane_sum[i] + longint'($signed(b[i])) * 8);
        lane_sum[i] = 0;
      end
      exp_q.push_back(e);
    end
    beat_n = (beat_n + 1) % AD;
    #1;
    data_in_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results never appeared", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Call right after the last beat of a group was accepted, with nothing pending.
  task automatic check_direct(input string name, input logic [OC-1:0][OW-1:0] exp);
    @(negedge clk);
    check({name, "_lat_early"}, 64'(data_out_valid), 64'(0));
    @(negedge clk);
    check({name, "_lat_valid"}, 64'(data_out_valid), 64'(1));
    check(name, 64'(data_out), 64'(exp));
  endtask

  task automatic one_hot_group(input logic [DP-1:0][IW-1:0] d, input logic [OC*DP-1:0][WW-1:0] w);
    send_beat(d, w, '0, 0, 1'b0);
    for (int k = 1; k < AD; k++) send_beat('0, '0, '0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    data_in_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(data_out_valid), 64'(0));
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_readies", 64'({data_in_ready, weight_ready, bias_ready}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    data_in_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
    rst = 1'b1;
    beat_n = 0;
    for (int i = 0; i < OC; i++) lane_sum[i] = 0;
  endtask

  initial begin
    logic [DP-1:0][IW-1:0]    d;
    logic [OC*DP-1:0][WW-1:0] w;
    logic [OC-1:0][BWD-1:0]   b;
    for (int i = 0; i < OC; i++) lane_sum[i] = 0;

    #2;
    check("init_out_valid", 64'(data_out_valid), 64'(0));
    check("init_readies", 64'({data_in_ready, weight_ready, bias_ready}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 8 beats of 1.0*1.0 on two elements plus bias 1.0 -> 17.0
    for (int k = 0; k < AD; k++) send_beat({16'd8, 16'd8}, {4{8'd16}}, {8'd16, 8'd16}, 0, 1'b0);
    check_direct("basic", {16'd272, 16'd272});
    drain();

    for (int k = 0; k < AD; k++)
      send_beat({2{16'h7FFF}}, {8'h80, 8'h80, 8'h7F, 8'h7F}, {8'h80, 8'h7F}, 0, 1'b0);
    check_direct("saturate", {16'h8000, 16'h7FFF});
    drain();

    one_hot_group({16'd3, 16'd4}, {8'd1, 8'd0, 8'd0, 8'd1});
    check_direct("round_4_3", {16'd0, 16'd1});
    drain();
    one_hot_group({16'd5, 16'hFFFC}, {8'd1, 8'd0, 8'd0, 8'd1});
    check_direct("round_m4_5", {16'd1, 16'd0});
    drain();

    one_hot_group({16'd0, 16'hFFB0}, {8'd0, 8'd8, 8'd0, 8'd8});
`ifdef CONV_ACC_RELU_EN
    check_direct("relu_m5", {16'd0, 16'd0});
`else
    check_direct("signed_m5", {16'hFFB0, 16'hFFB0});
`endif
    drain();

    // Backpressure across two full results, then a stalled third group.
    ready_mode = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 2 * AD; k++) begin
      d = $urandom; w = $urandom; b = 16'($urandom);
      send_beat(d, w, b, 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    data_in = $urandom; weight = $urandom; data_in_valid = 1'b1; weight_valid = 1'b1; bias_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_ready", 64'({data_in_ready, weight_ready}), 64'(0));
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0; weight_valid = 1'b0; bias_valid = 1'b0;
    check("bp_pending", 64'(exp_q.size()), 64'(2));
    ready_mode = 0;
    drain();

    // Reset in the middle of a group; only the fresh group may reach the output.
    for (int k = 0; k < 3; k++) begin
      d = $urandom; w = $urandom;
      send_beat(d, w, '0, 0, 1'b0);
    end
    do_reset();
    for (int k = 0; k < AD; k++) begin
      d = $urandom; w = $urandom; b = 16'($urandom);
      send_beat(d, w, b, 0, 1'b0);
    end
    drain();

    ready_mode = 2;
    for (int g = 0; g < 20; g++) begin
      for (int k = 0; k < AD; k++) begin
        d = $urandom; w = $urandom; b = 16'($urandom);
        send_beat(d, w, b, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
      end
    end
    ready_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
